// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode, state and datapath-select encodings for the multicycle control unit
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_EXEC_R   = 4'd7,
        ST_R_WB     = 4'd8,
        ST_EXEC_I   = 4'd9,
        ST_I_WB     = 4'd10,
        ST_BRANCH   = 4'd11,
        ST_JUMP     = 4'd12,
        ST_TRAP     = 4'd13,
        ST_JAL      = 4'd14
    } mc_state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } alu_src_b_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10,
        PC_RSVD   = 2'b11
    } pc_src_e;

    // States that stall on the memory handshake and therefore run the wait timer.
    function automatic logic is_wait_state(input mc_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory stall counter; expired when MAX_WAIT stall cycles have elapsed (0 disables)
module mc_wait_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);

    logic [CW-1:0] count_q, count_d;

    // Saturates at the limit: the FSM leaves the wait state once it is reached.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (tick && (count_q != LIMIT)) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (MAX_WAIT != 0) && (count_q == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS control FSM with memory timeout, traps and retired counter
// Optional MC_JAL_EN adds the JAL state and the link output.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_src,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             mem_timeout,
`ifdef MC_JAL_EN
    output logic             link,
`endif
    output logic [3:0]       state
);

    mc_state_e        state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] retired_q;
    logic             wait_clear, wait_tick, wait_expired;

    assign wait_clear = (state_d != state_q) && is_wait_state(state_d);
    assign wait_tick  = is_wait_state(state_q) && !mem_ready;

    mc_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .expired (wait_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        timeout_d  = timeout_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PC_ALU;
        instr_done = 1'b0;
`ifdef MC_JAL_EN
        link       = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_b = SRCB_IMM_SH2;
                case (opcode)
                    OP_RTYPE:         state_d = ST_EXEC_R;
                    OP_ADDI, OP_ANDI: state_d = ST_EXEC_I;
                    OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                    OP_BEQ, OP_BNE:   state_d = ST_BRANCH;
                    OP_J:             state_d = ST_JUMP;
`ifdef MC_JAL_EN
                    OP_JAL:           state_d = ST_JAL;
`endif
                    default: begin
                        state_d   = ST_TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (wait_expired) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else if (wait_expired) begin
                    state_d   = ST_TRAP;
                    timeout_d = 1'b1;
                end
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = ST_R_WB;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d   = ST_I_WB;
            end
            ST_I_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = ALU_SUB;
                pc_src     = PC_ALUOUT;
                pc_write   = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_JUMP: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
`ifdef MC_JAL_EN
            ST_JAL: begin
                pc_src     = PC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                link       = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
`endif
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_IDLE;
        endcase
    end

    assign retired     = retired_q;
    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control (vector table, random model, traps)
module tb_multicycle_control;

    localparam int MW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    opcode = 6'b0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg;
    logic          reg_dst, reg_write, alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic [CW-1:0] retired;
    logic [3:0]    state;
    logic          link_b;

    multicycle_control #(.MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .reg_dst     (reg_dst),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .retired     (retired),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout),
`ifdef MC_JAL_EN
        .link        (link_b),
`endif
        .state       (state)
    );

`ifndef MC_JAL_EN
    assign link_b = 1'b0;
`endif

    always #5 clk = ~clk;

    logic [16:0] all_out;
    logic [8:0]  last_vec;
    assign all_out  = {link_b, pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst,
                       reg_write, alu_src_a, alu_src_b, alu_op, pc_src, instr_done};
    assign last_vec = {pc_write, reg_write, mem_to_reg, reg_dst, mem_write, pc_src, alu_op};

    int checks = 0;
    int errors = 0;
    int model_ret = 0;

    typedef struct {
        logic [5:0] op;
        logic       z;
        int         len;
        logic [3:0] s2, s3, s4;
        logic [1:0] exec_op;
        logic [8:0] last;
    } vec_t;

    vec_t tbl[10];

    function automatic vec_t mk(input logic [5:0] op, input logic z, input int len, input logic [3:0] s2,
                                input logic [3:0] s3, input logic [3:0] s4, input logic [1:0] eo,
                                input logic [8:0] last);
        vec_t v;
        v.op = op; v.z = z; v.len = len; v.s2 = s2; v.s3 = s3; v.s4 = s4; v.exec_op = eo; v.last = last;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic mr);
        @(negedge clk);
        mem_ready = mr;
        #1;
    endtask

    task automatic check_retired(input string name);
        @(posedge clk);
        #1;
        chk(name, 64'(retired), 64'(model_ret % (1 << CW)));
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_ret = 0;
        chk({name, "_state"}, 64'(state), 64'd0);
        chk({name, "_flags"}, 64'({illegal_op, mem_timeout}), 64'd0);
        chk({name, "_outs"}, 64'(all_out), 64'd0);
        chk({name, "_retired"}, 64'(retired), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    function automatic int base_len(input logic [5:0] op);
        case (op)
            6'b100011:                               return 5;
            6'b101011, 6'b000000, 6'b001000, 6'b001100: return 4;
            default:                                 return 3;
        endcase
    endfunction

    logic [5:0] legal[9] = '{6'b000000, 6'b001000, 6'b001100, 6'b100011, 6'b101011,
                             6'b000100, 6'b000101, 6'b000010, 6'b000000};

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] es;
        tbl[0] = mk(6'b100011, 1'b0, 5, 4'd3, 4'd4, 4'd5, 2'b00, 9'b011000000);
        tbl[1] = mk(6'b101011, 1'b0, 4, 4'd3, 4'd6, 4'd0, 2'b00, 9'b000010000);
        tbl[2] = mk(6'b000000, 1'b0, 4, 4'd7, 4'd8, 4'd0, 2'b10, 9'b010100000);
        tbl[3] = mk(6'b001000, 1'b0, 4, 4'd9, 4'd10, 4'd0, 2'b00, 9'b010000000);
        tbl[4] = mk(6'b001100, 1'b0, 4, 4'd9, 4'd10, 4'd0, 2'b11, 9'b010000000);
        tbl[5] = mk(6'b000100, 1'b1, 3, 4'd11, 4'd0, 4'd0, 2'b01, 9'b100000101);
        tbl[6] = mk(6'b000101, 1'b1, 3, 4'd11, 4'd0, 4'd0, 2'b01, 9'b000000101);
        tbl[7] = mk(6'b000100, 1'b0, 3, 4'd11, 4'd0, 4'd0, 2'b01, 9'b000000101);
        tbl[8] = mk(6'b000101, 1'b0, 3, 4'd11, 4'd0, 4'd0, 2'b01, 9'b100000101);
        tbl[9] = mk(6'b000010, 1'b0, 3, 4'd12, 4'd0, 4'd0, 2'b00, 9'b100001000);

        #2;
        rst = 1'b1;
        #1;
        chk("reset_state", 64'(state), 64'd0);
        chk("reset_outs", 64'(all_out), 64'd0);
        chk("reset_retired", 64'(retired), 64'd0);
        chk("reset_flags", 64'({illegal_op, mem_timeout}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle_after_reset", 64'(state), 64'd0);

        for (int i = 0; i < 10; i++) begin
            opcode = tbl[i].op;
            zero   = tbl[i].z;
            for (int k = 0; k < tbl[i].len; k++) begin
                cyc(1'b1);
                case (k)
                    0:       es = 4'd1;
                    1:       es = 4'd2;
                    2:       es = tbl[i].s2;
                    3:       es = tbl[i].s3;
                    default: es = tbl[i].s4;
                endcase
                chk($sformatf("vec%0d_state%0d", i, k), 64'(state), 64'(es));
                chk($sformatf("vec%0d_done%0d", i, k), 64'(instr_done), 64'(k == tbl[i].len - 1));
                if (k == 0)
                    chk($sformatf("vec%0d_fetch", i), 64'({mem_read, i_or_d, pc_write, ir_write, alu_src_b}),
                        64'(6'b101101));
                if (k == 1)
                    chk($sformatf("vec%0d_decode_srcb", i), 64'(alu_src_b), 64'(2'b11));
                if (k == 2)
                    chk($sformatf("vec%0d_exec_aluop", i), 64'(alu_op), 64'(tbl[i].exec_op));
                if (k == tbl[i].len - 1)
                    chk($sformatf("vec%0d_final_ctl", i), 64'(last_vec), 64'(tbl[i].last));
            end
            model_ret++;
            check_retired($sformatf("vec%0d_retired", i));
        end

        // sw whose write is stalled three cycles; ready arrives exactly at the timeout limit
        opcode = 6'b101011;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
        for (int j = 0; j < 4; j++) begin
            cyc(j == 3);
            chk($sformatf("swstall_state%0d", j), 64'(state), 64'd6);
            chk($sformatf("swstall_memwrite%0d", j), 64'({mem_write, i_or_d}), 64'(2'b11));
            chk($sformatf("swstall_done%0d", j), 64'(instr_done), 64'(j == 3));
        end
        model_ret++;
        check_retired("swstall_retired");

        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            logic       mrq[$];
            int         fs, ms, exp_len, cnt;
            logic       done, mem_op;
            logic [1:0] wr_seen, wr_exp;
            op     = legal[$urandom_range(0, 8)];
            opcode = op;
            zero   = 1'($urandom_range(0, 1));
            fs     = $urandom_range(0, MW);
            ms     = $urandom_range(0, MW);
            mem_op = (op == 6'b100011) || (op == 6'b101011);
            exp_len = base_len(op) + fs + (mem_op ? ms : 0);
            mrq.delete();
            for (int s = 0; s < fs; s++) mrq.push_back(1'b0);
            repeat (3) mrq.push_back(1'b1);
            if (mem_op) for (int s = 0; s < ms; s++) mrq.push_back(1'b0);
            case (op)
                6'b000100: wr_exp = {zero, 1'b0};
                6'b000101: wr_exp = {!zero, 1'b0};
                6'b000010: wr_exp = 2'b10;
                6'b101011: wr_exp = 2'b00;
                default:   wr_exp = 2'b01;
            endcase
            cnt     = 0;
            done    = 1'b0;
            wr_seen = 2'b00;
            while (!done && cnt < 40) begin
                cyc((cnt < mrq.size()) ? mrq[cnt] : 1'b1);
                cnt++;
                if (instr_done) begin
                    done    = 1'b1;
                    wr_seen = {pc_write, reg_write};
                end
            end
            chk($sformatf("rand%0d_op%02h_latency", n, op), 64'(cnt), 64'(exp_len));
            chk($sformatf("rand%0d_op%02h_writes", n, op), 64'(wr_seen), 64'(wr_exp));
            model_ret++;
            check_retired($sformatf("rand%0d_retired", n));
        end

        // mem_ready stuck low in FETCH
        opcode = 6'b000000;
        zero   = 1'b0;
        for (int k = 0; k <= MW; k++) begin
            cyc(1'b0);
            chk($sformatf("tmo_fetch%0d", k), 64'(state), 64'd1);
        end
        cyc(1'b0);
        chk("tmo_state", 64'(state), 64'd13);
        chk("tmo_flags", 64'({illegal_op, mem_timeout}), 64'(2'b01));
        chk("tmo_outs", 64'(all_out), 64'd0);
        repeat (3) cyc(1'b1);
        chk("tmo_absorb_state", 64'(state), 64'd13);
        chk("tmo_absorb_outs", 64'(all_out), 64'd0);
        chk("tmo_retired", 64'(retired), 64'(model_ret % (1 << CW)));
        do_reset("tmo_rst");

        // one R-type to make the retired count nonzero, then an illegal opcode
        opcode = 6'b000000;
        repeat (4) cyc(1'b1);
        model_ret++;
        check_retired("ill_pre_retired");
        opcode = 6'b111111;
        cyc(1'b1);
        cyc(1'b1);
        chk("ill_decode", 64'(state), 64'd2);
        cyc(1'b1);
        chk("ill_state", 64'(state), 64'd13);
        chk("ill_flags", 64'({illegal_op, mem_timeout}), 64'(2'b10));
        chk("ill_outs", 64'(all_out), 64'd0);
        chk("ill_retired", 64'(retired), 64'd1);
        do_reset("ill_rst");

        opcode = 6'b000011;
        cyc(1'b1);
        cyc(1'b1);
        cyc(1'b1);
`ifdef MC_JAL_EN
        chk("jal_state", 64'(state), 64'd14);
        chk("jal_ctl", 64'({link_b, instr_done, pc_write, reg_write, pc_src}), 64'(6'b111110));
        model_ret++;
        check_retired("jal_retired");
`else
        chk("jal_trap_state", 64'(state), 64'd13);
        chk("jal_illegal", 64'(illegal_op), 64'd1);
        chk("jal_outs", 64'(all_out), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
